// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the DMA register copies LENGTH bytes from
// page {reg,8'h00} to DST_BASE, one byte every two cycles, as a bus master.
module oam_dma #(
  parameter logic [15:0] REG_ADDR  = 16'hFF46,
  parameter logic [15:0] DST_BASE  = 16'hFE00,
  parameter int unsigned LENGTH    = 160,
  parameter int unsigned START_DLY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_w,
  input  logic        cpu_write_enable,
  output logic [7:0]  cpu_data_r,
  output logic        cpu_data_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_w,
  output logic        dma_write_enable,
  input  logic [7:0]  dma_data_r,
  output logic        dma_active
);

  localparam int unsigned IDX_W = 9;
  localparam int unsigned DLY_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);
  localparam logic [DLY_W-1:0] DLY_INIT = (START_DLY == 0) ? '0 : DLY_W'(START_DLY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [7:0]         src_hi;
  logic [DLY_W-1:0]   dly_cnt;
  logic               reg_wr;

  assign reg_wr          = cpu_write_enable && (cpu_addr == REG_ADDR);
  assign cpu_data_active = !cpu_write_enable && (cpu_addr == REG_ADDR);
  assign idx_nxt         = idx + IDX_W'(1);

  // Bus outputs are registered alongside the state they belong to; the byte
  // read in READ is held in dma_data_w, which doubles as the copy latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= '0;
      src_hi           <= 8'h00;
      dly_cnt          <= '0;
      cpu_data_r       <= 8'h00;
      dma_addr         <= 16'h0000;
      dma_data_w       <= 8'h00;
      dma_write_enable <= 1'b0;
      dma_active       <= 1'b0;
    end else begin
      dma_addr         <= 16'h0000;
      dma_data_w       <= 8'h00;
      dma_write_enable <= 1'b0;

      if (reg_wr) begin
        // A restart wins over whatever the current state would do next.
        cpu_data_r <= cpu_data_w;
        src_hi     <= cpu_data_w;
        idx        <= '0;
        dly_cnt    <= DLY_INIT;
        dma_active <= 1'b1;
        if (START_DLY == 0) begin
          state    <= READ;
          dma_addr <= {cpu_data_w, 8'h00};
        end else begin
          state    <= DELAY;
        end
      end else begin
        case (state)
          IDLE: begin
            dma_active <= 1'b0;
          end
          DELAY: begin
            if (dly_cnt == '0) begin
              state    <= READ;
              dma_addr <= {src_hi, idx[7:0]};
            end else begin
              dly_cnt  <= dly_cnt - DLY_W'(1);
            end
          end
          READ: begin
            state            <= WRITE;
            dma_addr         <= DST_BASE + 16'(idx);
            dma_data_w       <= dma_data_r;
            dma_write_enable <= 1'b1;
          end
          WRITE: begin
            if (idx == LAST_IDX) begin
              state      <= IDLE;
              idx        <= '0;
              dma_active <= 1'b0;
            end else begin
              idx      <= idx_nxt;
              state    <= READ;
              dma_addr <= {src_hi, idx_nxt[7:0]};
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized scoreboard bench for oam_dma: a default instance (OAM copy) and a
// 256-byte, zero-delay instance to FF00 share the CPU stimulus and one memory.
module tb_oam_dma;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_w;
  logic        cpu_we;

  logic [7:0]  cdr   [2];
  logic        cact  [2];
  logic [15:0] daddr [2];
  logic [7:0]  ddw   [2];
  logic        dwe   [2];
  logic [7:0]  drd   [2];
  logic        dact  [2];

  logic [7:0]  mem [0:65535];
  bit          mem_ready = 1'b0;
  int          cyc = 0;
  bit          mon_en = 1'b0;

  // Reference model state: the transfer currently in flight per instance.
  bit          on  [2];
  int          n0  [2];
  logic [7:0]  src [2];
  logic [7:0]  cpu_r;
  exp_t        sb  [2][$];
  exp_t        mon_e;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  oam_dma u_dut0 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_w(cpu_data_w),
    .cpu_write_enable(cpu_we), .cpu_data_r(cdr[0]), .cpu_data_active(cact[0]),
    .dma_addr(daddr[0]), .dma_data_w(ddw[0]), .dma_write_enable(dwe[0]),
    .dma_data_r(drd[0]), .dma_active(dact[0])
  );

  oam_dma #(
    .REG_ADDR(16'hFF46), .DST_BASE(16'hFF00), .LENGTH(256), .START_DLY(0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_w(cpu_data_w),
    .cpu_write_enable(cpu_we), .cpu_data_r(cdr[1]), .cpu_data_active(cact[1]),
    .dma_addr(daddr[1]), .dma_data_w(ddw[1]), .dma_write_enable(dwe[1]),
    .dma_data_r(drd[1]), .dma_active(dact[1])
  );

  assign drd[0] = mem[daddr[0]];
  assign drd[1] = mem[daddr[1]];

  function automatic int p_dly(input int w);
    return (w == 0) ? 1 : 0;
  endfunction
  function automatic int p_len(input int w);
    return (w == 0) ? 160 : 256;
  endfunction
  function automatic logic [15:0] p_dst(input int w);
    return (w == 0) ? 16'hFE00 : 16'hFF00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected {active, write strobe, addr, data_w} for cycle m, from the
  // transfer timeline: START_DLY idle cycles, then read/write pairs.
  function automatic logic [25:0] exp_bus(input int w, input int m);
    int d, e, k;
    logic [15:0] a;
    if (!on[w] || m <= n0[w] || m > n0[w] + p_dly(w) + 2 * p_len(w))
      return 26'h0;
    d = m - n0[w] - 1;
    if (d < p_dly(w)) return {1'b1, 1'b0, 16'h0000, 8'h00};
    e = d - p_dly(w);
    k = e / 2;
    a = {src[w], 8'(k)};
    if (e % 2 == 0) return {1'b1, 1'b0, a, 8'h00};
    return {1'b1, 1'b1, 16'(p_dst(w) + 16'(k)), mem[a]};
  endfunction

  task automatic cancel_after(input int w, input int c);
    while (sb[w].size() > 0 && int'(sb[w][sb[w].size() - 1].cyc) > c)
      void'(sb[w].pop_back());
  endtask

  task automatic start_model(input int w, input int c, input logic [7:0] s);
    exp_t e;
    cancel_after(w, c);
    on[w]  = 1'b1;
    n0[w]  = c;
    src[w] = s;
    for (int k = 0; k < p_len(w); k++) begin
      e.cyc  = 32'(c + p_dly(w) + 2 * k + 2);
      e.addr = 16'(p_dst(w) + 16'(k));
      e.data = mem[{s, 8'(k)}];
      sb[w].push_back(e);
    end
  endtask

  // Model update: sees the same inputs the DUTs sample at this edge.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem_ready = 1'b1;
    end
    if (dwe[0]) mem[daddr[0]] = ddw[0];
    if (reset) begin
      cpu_r = 8'h00;
      for (int w = 0; w < 2; w++) begin
        cancel_after(w, cyc);
        on[w] = 1'b0;
      end
    end else if (cpu_we && cpu_addr == 16'hFF46) begin
      cpu_r = cpu_data_w;
      for (int w = 0; w < 2; w++) start_model(w, cyc, cpu_data_w);
    end
    cyc <= cyc + 1;
  end

  // Monitor: pops an expected write on every strobe, checks the bus each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int w = 0; w < 2; w++) begin
        if (dwe[w]) begin
          check($sformatf("sb%0d_expected_strobe", w), 64'(sb[w].size() > 0), 64'd1);
          if (sb[w].size() > 0) begin
            mon_e = sb[w].pop_front();
            check($sformatf("sb%0d_cycle", w), 64'(cyc), 64'(mon_e.cyc));
            check($sformatf("sb%0d_addr", w), 64'(daddr[w]), 64'(mon_e.addr));
            check($sformatf("sb%0d_data", w), 64'(ddw[w]), 64'(mon_e.data));
          end
        end
        check($sformatf("bus%0d", w), 64'({dact[w], dwe[w], daddr[w], ddw[w]}),
              64'(exp_bus(w, cyc)));
        check($sformatf("cpu_data_r%0d", w), 64'(cdr[w]), 64'(cpu_r));
        check($sformatf("cpu_data_active%0d", w), 64'(cact[w]),
              64'(!cpu_we && cpu_addr == 16'hFF46));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [7:0] v, output int n);
    cpu_addr   = 16'hFF46;
    cpu_data_w = v;
    cpu_we     = 1'b1;
    n          = cyc;
    step();
    cpu_we     = 1'b0;
    cpu_addr   = 16'h0000;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  function automatic logic [7:0] rand_src();
    return 8'($urandom_range(0, 8'hFD));
  endfunction

  task automatic check_drained(input string tag);
    check({tag, "_sb0_empty"}, 64'(sb[0].size()), 64'd0);
    check({tag, "_sb1_empty"}, 64'(sb[1].size()), 64'd0);
  endtask

  initial begin
    int n, n2, cnt;
    reset      = 1'b1;
    cpu_addr   = 16'h0000;
    cpu_data_w = 8'h00;
    cpu_we     = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset_active", 64'(dact[0]), 64'd0);
    check("reset_strobe", 64'(dwe[0]), 64'd0);
    check("reset_addr", 64'(daddr[0]), 64'h0);
    check("reset_data_w", 64'(ddw[0]), 64'h0);
    check("reset_cpu_data_r", 64'(cdr[0]), 64'h0);

    // Full OAM copy from C100, count active cycles, then inspect destination.
    reg_write(8'hC1, n);
    cpu_addr = 16'hFF46;
    cnt = 0;
    repeat (330) begin
      cnt += int'(dact[0]);
      step();
    end
    check("t1_active_cycles", 64'(cnt), 64'd321);
    for (int i = 0; i < 160; i++)
      check("t1_oam_byte", 64'(mem[16'hFE00 + 16'(i)]), 64'(8'(i) ^ 8'h5A));

    check("t3_readback", 64'(cdr[0]), 64'hC1);
    check("t3_active_read", 64'(cact[0]), 64'd1);
    cpu_we     = 1'b1;
    cpu_data_w = 8'hC1;
    #1;
    check("t3_active_write", 64'(cact[0]), 64'd0);
    step();
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    repeat (600) step();
    check_drained("t3");

    // Restart at byte 37, once during its READ and once during its WRITE.
    for (int ph = 0; ph < 2; ph++) begin
      reg_write(rand_src(), n);
      wait_until(n + 76 + ph);
      reg_write(8'hD0, n2);
      check("t2_restart_active", 64'(dact[0]), 64'd1);
      repeat (600) step();
      check_drained("t2");
    end

    // Reset mid-transfer around byte 80.
    reg_write(rand_src(), n);
    wait_until(n + 162 + int'($urandom_range(0, 1)));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t4_active", 64'(dact[0]), 64'd0);
    check("t4_strobe", 64'(dwe[0]), 64'd0);
    check("t4_cpu_data_r", 64'(cdr[0]), 64'h0);
    repeat (20) step();
    check_drained("t4");

    // Random restarts with unrelated CPU bus traffic in between.
    for (int t = 0; t < 4; t++) begin
      reg_write(rand_src(), n);
      repeat ($urandom_range(20, 400)) begin
        cpu_addr   = 16'($urandom);
        if (cpu_addr == 16'hFF46) cpu_addr = 16'hFF47;
        cpu_data_w = 8'($urandom);
        cpu_we     = 1'($urandom);
        step();
      end
      cpu_we   = 1'b0;
      cpu_addr = 16'h0000;
    end
    repeat (600) step();
    check_drained("rand");

    // 256-byte copy into FF00..FFFF on the second instance, no start delay.
    reg_write(rand_src(), n);
    check("t5_first_read", 64'(daddr[1]), 64'({src[1], 8'h00}));
    repeat (540) step();
    check_drained("t5");
    check("t5_idle", 64'(dact[1]), 64'd0);

    // Reset together with a register write: reset wins.
    cpu_addr   = 16'hFF46;
    cpu_data_w = 8'h77;
    cpu_we     = 1'b1;
    reset      = 1'b1;
    step();
    reset    = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    check("t6_active0", 64'(dact[0]), 64'd0);
    check("t6_active1", 64'(dact[1]), 64'd0);
    check("t6_cpu_data_r", 64'(cdr[0]), 64'h0);
    repeat (5) step();
    check("t6_still_idle", 64'(dact[0]), 64'd0);
    check_drained("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
